// File: rtl/ext_event_arbiter_pkg.sv
// Shared types and constants for the external event arbiter.
package ext_event_pkg;

  // Arbiter state: either looking for a pending line or holding an offer.
  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } arb_state_t;

  // Flop stages between a raw pin and the edge detector.
  localparam int SYNC_LATENCY = 3;

endpackage

// File: rtl/ext_event_arbiter_if.sv
// Event offer port: one index at a time, valid/ready handshake.
interface ext_event_arbiter_if #(
  parameter int NUM_INPUTS = 4
);
  localparam int ID_W = $clog2(NUM_INPUTS);

  logic            event_valid;
  logic [ID_W-1:0] event_id;
  logic            event_ready;

  modport master (
    output event_valid,
    output event_id,
    input  event_ready
  );

  modport slave (
    input  event_valid,
    input  event_id,
    output event_ready
  );
endinterface

// File: rtl/ext_event_arbiter_sync.sv
// Multi-bit flop-chain synchronizer for asynchronous pins. Each bit is an
// independent line, so no cross-bit coherency is implied.
module external_synchronizer
  import ext_event_pkg::*;
#(
  parameter int DATA_WIDTH = 1,
  parameter int STAGES     = SYNC_LATENCY
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] d,
  output logic [DATA_WIDTH-1:0] q
);

  logic [DATA_WIDTH-1:0] ff [STAGES];

  // Shift the raw lines through STAGES flops
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < STAGES; i++) ff[i] <= '0;
    end else begin
      ff[0] <= d;
      for (int i = 1; i < STAGES; i++) ff[i] <= ff[i-1];
    end
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/ext_event_arbiter.sv
// Collects rising edges from asynchronous external lines and offers them
// one at a time, round-robin, on a valid/ready port.
//
//   state | meaning
//   IDLE  | no offer outstanding; pick next pending line, if any
//   OFFER | event_valid high, event_id frozen until event_ready
module ext_event_arbiter
  import ext_event_pkg::*;
#(
  parameter  int NUM_INPUTS = 4,
  localparam int ID_W       = $clog2(NUM_INPUTS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_INPUTS-1:0] async_in,
  output logic [NUM_INPUTS-1:0] overflow,
  input  logic                  clear_overflow,
  ext_event_arbiter_if.master   evt
);

  localparam logic [ID_W-1:0] LAST_ID  = ID_W'(NUM_INPUTS - 1);
  localparam logic [ID_W:0]   NUM_WRAP = (ID_W+1)'(NUM_INPUTS);

  arb_state_t            state;
  logic [ID_W-1:0]       last_grant;
  logic [NUM_INPUTS-1:0] sync;
  logic [NUM_INPUTS-1:0] hist;
  logic [NUM_INPUTS-1:0] pending;
  logic [NUM_INPUTS-1:0] rise;
  logic [NUM_INPUTS-1:0] grant_done;
  logic [NUM_INPUTS-1:0] ovf_set;

  // Round-robin pick: rotate so the line after last grant sits at bit 0,
  // take the lowest set bit, then map back to an absolute index.
  function automatic logic [ID_W-1:0] rr_pick(
    input logic [NUM_INPUTS-1:0] req,
    input logic [ID_W-1:0]       last
  );
    logic [ID_W-1:0]         start;
    logic [2*NUM_INPUTS-1:0] dbl;
    logic [NUM_INPUTS-1:0]   rot;
    logic [ID_W-1:0]         found;
    logic [ID_W:0]           sum;
    start = (last == LAST_ID) ? '0 : last + ID_W'(1);
    dbl   = {req, req} >> start;
    rot   = dbl[NUM_INPUTS-1:0];
    found = '0;
    for (int i = NUM_INPUTS - 1; i >= 0; i--) begin
      if (rot[i]) found = ID_W'(i);
    end
    sum = {1'b0, found} + {1'b0, start};
    if (sum >= NUM_WRAP) sum = sum - NUM_WRAP;
    return sum[ID_W-1:0];
  endfunction

  external_synchronizer #(
    .DATA_WIDTH (NUM_INPUTS),
    .STAGES     (SYNC_LATENCY)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (async_in),
    .q     (sync)
  );

  assign rise = sync & ~hist;

  // One-hot of the line whose offer completes this cycle
  always_comb begin
    grant_done = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      if (evt.event_valid && evt.event_ready && evt.event_id == ID_W'(i))
        grant_done[i] = 1'b1;
    end
  end

  // A rise on a line that stays pending is a lost event; a rise that lands
  // with its own handshake re-arms the line instead.
  assign ovf_set = rise & pending & ~grant_done;

  // Edge history, pending latch and sticky overflow (set beats clear)
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hist     <= '0;
      pending  <= '0;
      overflow <= '0;
    end else begin
      hist     <= sync;
      pending  <= (pending & ~grant_done) | rise;
      overflow <= clear_overflow ? ovf_set : (overflow | ovf_set);
    end
  end

  // Offer FSM; arbitration only happens in IDLE, giving a bubble per event
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      evt.event_valid <= 1'b0;
      evt.event_id    <= '0;
      last_grant      <= LAST_ID;
    end else begin
      case (state)
        IDLE: begin
          if (|pending) begin
            evt.event_id    <= rr_pick(pending, last_grant);
            evt.event_valid <= 1'b1;
            state           <= OFFER;
          end
        end
        OFFER: begin
          if (evt.event_ready) begin
            evt.event_valid <= 1'b0;
            last_grant      <= evt.event_id;
            state           <= IDLE;
          end
        end
        default: begin
          evt.event_valid <= 1'b0;
          state           <= IDLE;
        end
      endcase
    end
  end

endmodule
